// File: rtl/serial_adder.sv
// Bit-serial adder: operands are loaded in parallel, then one full-adder step per clock, LSB first.
// A carry flip-flop links successive bits. The result is held until the next accepted start.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             ck,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             s_bit,
    output logic             c_bit
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sumBit;
    logic             carryNext;

    // Full-adder cell built from two half adders.
    always_comb begin
        sumBit    = sa_q[0] ^ sb_q[0] ^ carry_q;
        carryNext = (sa_q[0] & sb_q[0]) | (carry_q & (sa_q[0] ^ sb_q[0]));
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                carry_d            = carryNext;
                acc_d              = acc_q >> 1;
                acc_d[WIDTH-1]     = sumBit;
                sa_d               = sa_q >> 1;
                sb_d               = sb_q >> 1;
                cnt_d              = cnt_q + CW'(1);
                // The last bit completes the accumulator in this same step.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = acc_d;
                    cout_d  = carryNext;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ck) begin
        if (reset) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign sum   = sum_q;
    assign cout  = cout_q;
    assign s_bit = (state_q == RUN) ? sumBit : 1'b0;
    assign c_bit = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomised checks of serial_adder at widths 8, 1 and 32.
// Expected sums come from hand-computed constants or plain integer addition.
module tb_serial_adder;

    logic        ck = 1'b0;
    logic        reset;
    logic        start, cin;
    logic [7:0]  a, b, sum;
    logic        busy, done, cout, sBit, cBit;

    logic        start1, a1, b1, cin1, busy1, done1, sum1, cout1, sBit1, cBit1;

    logic        start32, cin32, busy32, done32, cout32, sBit32, cBit32;
    logic [31:0] a32, b32, sum32;

    int          vecCount  = 0;
    int          missCount = 0;
    logic [7:0]  lastSum;

    serial_adder #(.WIDTH(8)) dut8 (
        .ck(ck), .reset(reset), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .s_bit(sBit), .c_bit(cBit)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .ck(ck), .reset(reset), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .s_bit(sBit1), .c_bit(cBit1)
    );

    serial_adder #(.WIDTH(32)) dut32 (
        .ck(ck), .reset(reset), .start(start32), .a(a32), .b(b32), .cin(cin32),
        .busy(busy32), .done(done32), .sum(sum32), .cout(cout32), .s_bit(sBit32), .c_bit(cBit32)
    );

    always #5 ck = ~ck;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    // One WIDTH=8 addition with per-cycle done checks; holdStart keeps start high through RUN and DONE.
    task automatic runOp8(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                          input bit holdStart, input bit carryHigh);
        logic [8:0] expv;
        expv  = {1'b0, av} + {1'b0, bv} + {8'd0, ci};
        a     = av;
        b     = bv;
        cin   = ci;
        start = 1'b1;
        tick();
        vecCount++;
        if (busy !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL op_busy: got %b want 1 (a=%h b=%h)", busy, av, bv);
        end
        vecCount++;
        if (sum !== lastSum) begin
            missCount++;
            $display("[TB] FAIL op_sum_held: got %h want %h", sum, lastSum);
        end
        if (!holdStart) start = 1'b0;
        a   = 8'($urandom);
        b   = 8'($urandom);
        cin = 1'($urandom);
        for (int i = 1; i <= 8; i++) begin
            tick();
            vecCount++;
            if (done !== logic'(i == 8)) begin
                missCount++;
                $display("[TB] FAIL op_done_cycle%0d: got %b want %b", i, done, logic'(i == 8));
            end
            if (carryHigh) begin
                vecCount++;
                if (cBit !== 1'b1) begin
                    missCount++;
                    $display("[TB] FAIL op_carry_cycle%0d: got %b want 1", i, cBit);
                end
            end
        end
        vecCount++;
        if ({cout, sum} !== expv) begin
            missCount++;
            $display("[TB] FAIL op_result: a=%h b=%h cin=%b got %h want %h", av, bv, ci, {cout, sum}, expv);
        end
        vecCount++;
        if (sBit !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL op_sbit_done: got %b want 0", sBit);
        end
        tick();
        vecCount++;
        if ({busy, done} !== 2'b00) begin
            missCount++;
            $display("[TB] FAIL op_idle_after: busy/done got %b want 00", {busy, done});
        end
        start   = 1'b0;
        lastSum = expv[7:0];
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        start32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        vecCount++;
        if ({busy, done, cout, sBit, cBit} !== 5'b0) begin
            missCount++;
            $display("[TB] FAIL reset_flags: got %b want 00000", {busy, done, cout, sBit, cBit});
        end
        vecCount++;
        if (sum !== 8'h00) begin
            missCount++;
            $display("[TB] FAIL reset_sum: got %h want 00", sum);
        end
        vecCount++;
        if ({busy1, busy32} !== 2'b00) begin
            missCount++;
            $display("[TB] FAIL reset_busy_other: got %b want 00", {busy1, busy32});
        end
        lastSum = 8'h00;
    endtask

    task automatic test_basic();
        a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        vecCount++;
        if (sBit !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL basic_sbit1: got %b want 1", sBit);
        end
        for (int i = 2; i <= 8; i++) begin
            tick();
            vecCount++;
            if (done !== logic'(i == 8)) begin
                missCount++;
                $display("[TB] FAIL basic_done_cycle%0d: got %b want %b", i, done, logic'(i == 8));
            end
        end
        vecCount++;
        if ({cout, sum} !== 9'h096) begin
            missCount++;
            $display("[TB] FAIL basic_result: got %h want 096", {cout, sum});
        end
        tick();
        vecCount++;
        if ({busy, done} !== 2'b00) begin
            missCount++;
            $display("[TB] FAIL basic_idle: got %b want 00", {busy, done});
        end
        lastSum = 8'h96;
    endtask

    task automatic test_carry();
        runOp8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
        runOp8(8'hFF, 8'h00, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        int n;
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        tick();
        tick(); tick(); tick();
        a = 8'h10;
        n = 0;
        while (done !== 1'b1 && n < 20) begin tick(); n++; end
        vecCount++;
        if (done !== 1'b1 || sum !== 8'h02) begin
            missCount++;
            $display("[TB] FAIL b2b_first: done=%b sum got %h want 02", done, sum);
        end
        tick();
        n = 0;
        while (done !== 1'b1 && n < 20) begin tick(); n++; end
        vecCount++;
        if (done !== 1'b1 || sum !== 8'h11) begin
            missCount++;
            $display("[TB] FAIL b2b_second: done=%b sum got %h want 11", done, sum);
        end
        start = 1'b0;
        tick();
        vecCount++;
        if (busy !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL b2b_idle: got %b want 0", busy);
        end
        lastSum = 8'h11;
    endtask

    task automatic test_reset_abort();
        int pulses;
        a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vecCount++;
        if ({busy, done, cout, sBit, cBit} !== 5'b0 || sum !== 8'h00) begin
            missCount++;
            $display("[TB] FAIL abort_state: flags got %b want 00000, sum got %h want 00",
                     {busy, done, cout, sBit, cBit}, sum);
        end
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        vecCount++;
        if (pulses != 0) begin
            missCount++;
            $display("[TB] FAIL abort_no_done: got %0d pulses want 0", pulses);
        end
        lastSum = 8'h00;
        runOp8(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_width1();
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        vecCount++;
        if ({busy1, done1, sBit1, cBit1} !== 4'b1011) begin
            missCount++;
            $display("[TB] FAIL w1_run: busy/done/s/c got %b want 1011", {busy1, done1, sBit1, cBit1});
        end
        tick();
        vecCount++;
        if ({done1, cout1, sum1, sBit1} !== 4'b1110) begin
            missCount++;
            $display("[TB] FAIL w1_done: done/cout/sum/s got %b want 1110", {done1, cout1, sum1, sBit1});
        end
        tick();
        vecCount++;
        if ({busy1, done1} !== 2'b00) begin
            missCount++;
            $display("[TB] FAIL w1_idle: got %b want 00", {busy1, done1});
        end
    endtask

    task automatic test_width32();
        a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0001; cin32 = 1'b0; start32 = 1'b1;
        tick();
        start32 = 1'b0;
        vecCount++;
        if ({busy32, sBit32, cBit32} !== 3'b100) begin
            missCount++;
            $display("[TB] FAIL w32_run: busy/s/c got %b want 100", {busy32, sBit32, cBit32});
        end
        for (int i = 1; i <= 32; i++) begin
            tick();
            vecCount++;
            if (done32 !== logic'(i == 32) || cBit32 !== 1'b1) begin
                missCount++;
                $display("[TB] FAIL w32_cycle%0d: done/c got %b%b want %b1", i, done32, cBit32, logic'(i == 32));
            end
        end
        vecCount++;
        if ({cout32, sum32} !== 33'h1_0000_0000) begin
            missCount++;
            $display("[TB] FAIL w32_result: got %h want 100000000", {cout32, sum32});
        end
        tick();
        vecCount++;
        if (busy32 !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL w32_idle: got %b want 0", busy32);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 1000; n++) begin
            runOp8(8'($urandom), 8'($urandom), 1'($urandom), bit'(n % 2), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_back_to_back();
        test_reset_abort();
        test_width1();
        test_width32();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
